// File: rtl/axi4_sram_responder_if.sv
// axi4_sram_responder_if: AXI4 bus bundle between a master and the SRAM responder
// Carries the AW, W, B, AR and R channels; master drives requests, slave drives responses.
interface axi4_sram_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi4_sram_responder.sv
// axi4_sram_responder: single-outstanding AXI4 subordinate backed by a word-addressed SRAM
// Ports: clk, rst_n (async active-low), bus (axi4_sram_responder_if.slave: AW/W/B/AR/R channels).
module axi4_sram_responder #(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 64,
    parameter int                ID_W   = 4,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    axi4_sram_responder_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int SH = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [2:0] IDLE = 3'd0, RLAT = 3'd1, RDATA = 3'd2, WDATA = 3'd3, WRESP = 3'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [2:0]        state;
    logic              last_rd;
    logic [IW-1:0]     idx;
    logic [7:0]        len;
    logic [1:0]        burst, resp;
    logic [ID_W-1:0]   id;
    logic [8:0]        beat;
    logic [CW-1:0]     lat;

    // last_rd=1 means the previous contended grant went to read, so write wins the next tie
    logic take_aw, take_ar;
    assign take_aw = bus.awvalid && bus.awready && (!bus.arvalid || last_rd);
    assign take_ar = bus.arvalid && bus.arready && !take_aw;

    logic [ADDR_W-1:0] a_addr, a_off;
    logic [ADDR_W:0]   a_end;
    logic [7:0]        a_len;
    logic [2:0]        a_size;
    logic [1:0]        a_burst, a_resp;
    logic [ID_W-1:0]   a_id;
    logic [IW-1:0]     a_idx, nidx;
    logic              at_end;
    always_comb begin
        a_addr  = take_aw ? bus.awaddr  : bus.araddr;
        a_len   = take_aw ? bus.awlen   : bus.arlen;
        a_size  = take_aw ? bus.awsize  : bus.arsize;
        a_burst = take_aw ? bus.awburst : bus.arburst;
        a_id    = take_aw ? bus.awid    : bus.arid;
        a_off   = a_addr - BASE;
        a_idx   = IW'(a_off >> SH);
        a_end   = {1'b0, a_off >> SH} + (ADDR_W+1)'(a_len);
        a_resp  = (a_addr < BASE || a_end >= (ADDR_W+1)'(DEPTH)) ? 2'b11 :
                  (a_size > 3'(SH) || a_burst[1]) ? 2'b10 : 2'b00;
        nidx    = burst == 2'b01 ? idx + 1'b1 : idx;
        at_end  = beat == {1'b0, len};
    end

    always_ff @(posedge clk)
        if (state == WDATA && bus.wvalid && bus.wready && resp == 2'b00)
            for (int i = 0; i < NB; i++)
                if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_rd     <= 1'b1;
            bus.awready <= 1'b0;
            bus.arready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= '0;
            bus.bid     <= '0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= '0;
            bus.rlast   <= 1'b0;
            bus.rid     <= '0;
            idx         <= '0;
            len         <= '0;
            burst       <= '0;
            resp        <= '0;
            id          <= '0;
            beat        <= '0;
            lat         <= '0;
        end else begin
            case (state)
                IDLE: if (take_aw || take_ar) begin
                    bus.awready <= 1'b0;
                    bus.arready <= 1'b0;
                    if (bus.awvalid && bus.arvalid) last_rd <= take_ar;
                    idx   <= a_idx;
                    len   <= a_len;
                    burst <= a_burst;
                    resp  <= a_resp;
                    id    <= a_id;
                    beat  <= '0;
                    lat   <= '0;
                    if (take_aw) begin
                        state      <= WDATA;
                        bus.wready <= 1'b1;
                    end else if (RD_LAT == 1) begin
                        state      <= RDATA;
                        bus.rvalid <= 1'b1;
                        bus.rdata  <= a_resp == 2'b00 ? mem[a_idx] : '0;
                        bus.rresp  <= a_resp;
                        bus.rid    <= a_id;
                        bus.rlast  <= a_len == 8'd0;
                    end else state <= RLAT;
                end else begin
                    bus.awready <= 1'b1;
                    bus.arready <= 1'b1;
                end
                RLAT: if (lat == CW'(RD_LAT - 2)) begin
                    state      <= RDATA;
                    bus.rvalid <= 1'b1;
                    bus.rdata  <= resp == 2'b00 ? mem[idx] : '0;
                    bus.rresp  <= resp;
                    bus.rid    <= id;
                    bus.rlast  <= at_end;
                end else lat <= lat + 1'b1;
                RDATA: if (bus.rready) begin
                    if (at_end) begin
                        state       <= IDLE;
                        bus.rvalid  <= 1'b0;
                        bus.rlast   <= 1'b0;
                        bus.awready <= 1'b1;
                        bus.arready <= 1'b1;
                    end else begin
                        beat      <= beat + 1'b1;
                        idx       <= nidx;
                        bus.rdata <= resp == 2'b00 ? mem[nidx] : '0;
                        bus.rlast <= beat + 9'd1 == {1'b0, len};
                    end
                end
                WDATA: if (bus.wvalid) begin
                    beat <= beat + 1'b1;
                    idx  <= nidx;
                    if (bus.wlast || at_end) begin
                        state      <= WRESP;
                        bus.wready <= 1'b0;
                        bus.bvalid <= 1'b1;
                        bus.bid    <= id;
                        // wlast and the final beat must coincide; any mismatch is a protocol error
                        bus.bresp  <= (bus.wlast != at_end) ? 2'b10 : resp;
                    end
                end
                WRESP: if (bus.bready) begin
                    state       <= IDLE;
                    bus.bvalid  <= 1'b0;
                    bus.awready <= 1'b1;
                    bus.arready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sram_responder.sv
// tb_axi4_sram_responder: directed self-checking bench for axi4_sram_responder (RD_LAT=3)
module tb_axi4_sram_responder;
    logic clk, rst_n;
    int   errs = 0, checks = 0;
    logic [63:0] rd_q [8];
    logic [1:0]  rr_q [8];
    logic        rl_q [8];
    logic [3:0]  ri_q [8];
    logic [1:0]  bresp_o;
    logic [3:0]  bid_o;
    int          lat_o;

    axi4_sram_responder_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();
    axi4_sram_responder #(.RD_LAT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return bus.awready;
            1: return bus.arready;
            2: return bus.wready;
            3: return bus.bvalid;
            default: return bus.rvalid;
        endcase
    endfunction

    task automatic wait_for(input int w, input string tag);
        int n = 0;
        while (!sig(w) && n < 100) begin @(posedge clk); #1; n++; end
        if (!sig(w)) check({tag, "_timeout"}, 64'(sig(w)), 64'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input logic [3:0] id, input logic [63:0] d0,
                             input logic [7:0] strb, input int wl);
        bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size; bus.awid = id;
        bus.awvalid = 1'b1;
        wait_for(0, "aw");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int k = 0; k <= wl; k++) begin
            bus.wvalid = 1'b1; bus.wdata = d0 + 64'(k); bus.wstrb = strb; bus.wlast = (k == wl);
            wait_for(2, "w");
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        wait_for(3, "b");
        bresp_o = bus.bresp; bid_o = bus.bid;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input bit slow);
        bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = 3'd3; bus.arid = id;
        bus.arvalid = 1'b1;
        wait_for(1, "ar");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        lat_o = 1;
        while (!bus.rvalid && lat_o < 100) begin @(posedge clk); #1; lat_o++; end
        for (int k = 0; k <= int'(len); k++) begin
            wait_for(4, "r");
            rd_q[k] = bus.rdata; rr_q[k] = bus.rresp; rl_q[k] = bus.rlast; ri_q[k] = bus.rid;
            if (slow && k[0] == 1'b0) begin
                @(posedge clk); #1;
                check("r_stable_data", bus.rdata, rd_q[k]);
                check("r_stable_last", 64'(bus.rlast), 64'(rl_q[k]));
            end
            bus.rready = 1'b1;
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
        check("ar_ready_after", 64'(bus.arready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.rready = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast}), 64'd0);
        check("rst_resp", 64'({bus.rresp, bus.bresp, bus.rid, bus.bid}), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        axi_write(32'h8000_0000, 8'd0, 2'b01, 3'd3, 4'd3, 64'h1122_3344_5566_7788, 8'hFF, 0);
        check("w0_bresp", 64'(bresp_o), 64'd0);
        check("w0_bid", 64'(bid_o), 64'd3);
        axi_read(32'h8000_0000, 8'd0, 2'b01, 4'd5, 0);
        check("r0_latency", 64'(lat_o), 64'd3);
        check("r0_data", rd_q[0], 64'h1122_3344_5566_7788);
        check("r0_resp", 64'(rr_q[0]), 64'd0);
        check("r0_last", 64'(rl_q[0]), 64'd1);
        check("r0_id", 64'(ri_q[0]), 64'd5);

        axi_write(32'h8000_0010, 8'd3, 2'b01, 3'd3, 4'd1, 64'hA0, 8'hFF, 3);
        check("incr_bresp", 64'(bresp_o), 64'd0);
        axi_read(32'h8000_0010, 8'd3, 2'b01, 4'd2, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("incr_data%0d", k), rd_q[k], 64'hA0 + 64'(k));
            check($sformatf("incr_last%0d", k), 64'(rl_q[k]), 64'(k == 3));
        end

        axi_write(32'h8000_0100, 8'd0, 2'b01, 3'd3, 4'd0, 64'd0, 8'hFF, 0);
        axi_write(32'h8000_0100, 8'd0, 2'b01, 3'd3, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
        axi_read(32'h8000_0100, 8'd0, 2'b01, 4'd0, 0);
        check("strobe_word", rd_q[0], 64'h0000_0000_FFFF_FFFF);
        axi_write(32'h8000_0108, 8'd1, 2'b00, 3'd3, 4'd0, 64'h1, 8'hFF, 1);
        check("fixed_bresp", 64'(bresp_o), 64'd0);
        axi_read(32'h8000_0108, 8'd0, 2'b01, 4'd0, 0);
        check("fixed_word", rd_q[0], 64'h2);

        axi_read(32'h7FFF_FFF8, 8'd0, 2'b01, 4'd6, 0);
        check("below_base_resp", 64'(rr_q[0]), 64'd3);
        check("below_base_data", rd_q[0], 64'd0);
        axi_read(32'h8000_7FF8, 8'd1, 2'b01, 4'd6, 0);
        check("top_overrun_resp0", 64'(rr_q[0]), 64'd3);
        check("top_overrun_resp1", 64'(rr_q[1]), 64'd3);
        check("top_overrun_last1", 64'(rl_q[1]), 64'd1);
        axi_read(32'h8000_7FF8, 8'd0, 2'b01, 4'd6, 0);
        check("top_word_resp", 64'(rr_q[0]), 64'd0);
        axi_write(32'h8000_0000, 8'd0, 2'b10, 3'd3, 4'd7, 64'hDEAD, 8'hFF, 0);
        check("wrap_bresp", 64'(bresp_o), 64'd2);
        check("wrap_bid", 64'(bid_o), 64'd7);
        axi_read(32'h8000_0000, 8'd0, 2'b01, 4'd0, 0);
        check("wrap_mem_kept", rd_q[0], 64'h1122_3344_5566_7788);
        axi_write(32'h8000_0200, 8'd3, 2'b01, 3'd3, 4'd0, 64'h10, 8'hFF, 1);
        check("early_wlast_bresp", 64'(bresp_o), 64'd2);

        // contended request, round 1: write favoured after reset
        bus.awaddr = 32'h8000_0300; bus.awlen = 0; bus.awburst = 2'b01; bus.awsize = 3'd3; bus.awid = 4'd1;
        bus.araddr = 32'h8000_0300; bus.arlen = 0; bus.arburst = 2'b01; bus.arsize = 3'd3; bus.arid = 4'd2;
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        wait_for(0, "arb1_aw");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        check("arb1_write_first", 64'(bus.wready), 64'd1);
        check("arb1_no_ar", 64'(bus.arready), 64'd0);
        bus.wvalid = 1'b1; bus.wdata = 64'h55; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        wait_for(3, "arb1_b");
        bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
        wait_for(1, "arb1_ar");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        wait_for(4, "arb1_r");
        check("arb1_read_after", bus.rdata, 64'h55);
        bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
        // round 2: read favoured
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        wait_for(1, "arb2_ar");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("arb2_no_aw", 64'({bus.awready, bus.wready}), 64'd0);
        wait_for(4, "arb2_r");
        check("arb2_read_first", bus.rdata, 64'h55);
        bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
        wait_for(0, "arb2_aw");
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 64'h66; bus.wlast = 1'b1;
        wait_for(2, "arb2_w");
        @(posedge clk); #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        wait_for(3, "arb2_b");
        check("arb2_bid", 64'(bus.bid), 64'd1);
        bus.bready = 1'b1; @(posedge clk); #1; bus.bready = 1'b0;
        axi_read(32'h8000_0300, 8'd0, 2'b01, 4'd0, 0);
        check("arb2_write_after", rd_q[0], 64'h66);

        // reset during beat 2 of a 4-beat read
        bus.araddr = 32'h8000_0010; bus.arlen = 8'd3; bus.arburst = 2'b01; bus.arid = 4'd4;
        bus.arvalid = 1'b1;
        wait_for(1, "rst_ar");
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        wait_for(4, "rst_r0");
        bus.rready = 1'b1; @(posedge clk); #1; bus.rready = 1'b0;
        wait_for(4, "rst_r1");
        check("rst_mid_beat2", bus.rdata, 64'hA1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast}), 64'd0);
        check("rst_mid_data", bus.rdata, 64'd0);
        check("rst_mid_resp", 64'({bus.rresp, bus.bresp, bus.rid, bus.bid}), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h8000_0018, 8'd0, 2'b01, 4'd9, 0);
        check("post_rst_data", rd_q[0], 64'hA1);
        check("post_rst_id", 64'(ri_q[0]), 64'd9);
        check("post_rst_last", 64'(rl_q[0]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
- AXI4 responder (subordinate) end of the Ifu/Exu instruction- and data-memory buses.
- Backs a word-addressed SRAM array and services one transaction at a time.
- Supports FIXED/INCR bursts, programmable read latency, per-byte write strobes and SLVERR/DECERR responses.
- Drop-in target for either master port; replaces the flat single-beat memory model so burst-capable masters can be verified.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width; beat = DATA_W/8 bytes.
- ID_W, 4, ID width.
- DEPTH, 4096, number of DATA_W words in the array.
- BASE, 32'h8000_0000, first mapped byte address.
- RD_LAT, 1, cycles from AR handshake to first rvalid (≥1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  write-address handshake
- awaddr  in  ADDR_W; awid in ID_W; awlen in 8; awsize in 3; awburst in 2
- wvalid/wready  in/out  1; wdata in DATA_W; wstrb in DATA_W/8; wlast in 1
- bvalid/bready  out/in  1; bresp out 2; bid out ID_W
- arvalid/arready  in/out  1; araddr in ADDR_W; arid in ID_W; arlen in 8; arsize in 3; arburst in 2
- rvalid/rready  out/in  1; rdata out DATA_W; rresp out 2; rlast out 1; rid out ID_W

Behaviour:
- Reset (async assert, sync release): state IDLE; every out 0 (awready, arready, wready, bvalid, rvalid, rlast, rdata, rresp, bresp, rid, bid); grant pointer → read. Array contents not reset. Reset mid-burst drops the transaction; no B/R completes.
- States: IDLE, RLAT, RDATA, WDATA, WRESP.
- IDLE: awready/arready are registered and asserted only in IDLE.
  - Only one of arvalid/awvalid high → accept it.
  - Both high → accept the one the round-robin pointer favours, then flip the pointer.
  - Accept captures addr, id, len, burst; beat counter = 0.
- Decode per transaction:
  - word index = (addr−BASE)>>3.
  - addr < BASE or index+len ≥ DEPTH → DECERR (2'b11).
  - awsize/arsize > 3 or burst ∉ {00,01} → SLVERR (2'b10).
  - Otherwise OKAY (2'b00).
  - Any error: no array read/write; rdata = 0.
- Read path:
  - RLAT counts RD_LAT−1 cycles (RD_LAT=1 → straight to RDATA next cycle).
  - RDATA: rvalid=1; rdata/rresp/rid/rlast held stable until rready.
  - Each accepted beat: INCR index+1, FIXED index unchanged.
  - rlast=1 when beat == len.
  - After the last beat handshake → IDLE; arready high the following cycle.
- Write path:
  - WDATA: wready=1; each wvalid&wready beat writes the bytes where wstrb[i]=1, then advances the index as for reads.
  - wlast on beat < len → terminate early, bresp SLVERR.
  - beat == len without wlast → bresp SLVERR; still → WRESP.
  - Otherwise bresp = decoded response.
  - WRESP: bvalid=1, bid=awid, held until bready → IDLE.
- Single outstanding transaction; no AW/AR accepted outside IDLE.
- wvalid seen in IDLE before AW is not consumed: wready=0 until WDATA.
- len arithmetic is 8-bit; beat counter 9-bit so len=255 gives 256 beats with no wrap.

Test Plan:
- Single read: RD_LAT=3, mem[0]=64'h1122_3344_5566_7788, AR 0x8000_0000 len0 id5 → rvalid exactly 3 cycles after AR handshake, rdata 0x1122334455667788, rresp 0, rlast 1, rid 5.
- INCR write then read: AW 0x8000_0010 len3, four beats 0xA0..0xA3 with wstrb 8'hFF, rready toggling → bresp 0; read back returns A0,A1,A2,A3 with rlast only on the 4th; rdata stable across rready-low cycles.
- Strobe/FIXED write: wstrb 8'h0F, data 64'hFFFF_FFFF_FFFF_FFFF on a zeroed word → word = 64'h0000_0000_FFFF_FFFF. FIXED len1 writes 0x1 then 0x2 → word = 0x2.
- Errors:
  - AR 0x7FFF_FFF8 → rresp 2'b11, rdata 0.
  - AW with awburst 2'b10 → bresp 2'b10, memory unchanged.
  - AW len3 with wlast on beat 1 → bresp 2'b10 after 2 beats.
- Arbitration: awvalid and arvalid rise in the same cycle, twice in a row → first write, then read (grant alternates); no double accept.
- Reset mid-read: rst_n low during RDATA beat 2 of 4 → all outputs 0 within the same cycle; after release, a new AR completes normally.
